// File: rtl/cpu_control.sv
// Two-cycle DECODE/EXEC control unit with an IN handshake on a synchronized push-button.
// Define OVF_TRAP_EN to halt on overflow during add, sub and ADDI.
module cpu_control (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       of_i,
  input  logic       confirm_i,
  output logic       halt_o,
  output logic       sreg_o,
  output logic       smem_o,
  output logic       sdisplay_o,
  output logic       smemtoreg_o,
  output logic       smux5_o,
  output logic       smux32_o,
  output logic [1:0] smux16_o,
  output logic [2:0] smux_pc_o,
  output logic [3:0] salu_o,
  output logic [1:0] state_out_o,
  output logic       illegal_o
);

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpIn    = 6'b011100;
  localparam logic [5:0] OpOut   = 6'b011101;
  localparam logic [5:0] OpHlt   = 6'b111111;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnJr  = 6'b001000;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluSlt = 4'b0100;
  localparam logic [3:0] AluSll = 4'b0101;
  localparam logic [3:0] AluSrl = 4'b0110;

  localparam logic [2:0] PcNext    = 3'b000;
  localparam logic [2:0] PcBeq     = 3'b001;
  localparam logic [2:0] PcBne     = 3'b010;
  localparam logic [2:0] PcJump    = 3'b011;
  localparam logic [2:0] PcJumpReg = 3'b100;

  typedef enum logic [1:0] {
    StDecode = 2'b00,
    StExec   = 2'b01,
    StWaitIn = 2'b10,
    StHalted = 2'b11
  } state_e;

  state_e state_q, state_d;
  logic   conf_meta_q, conf_sync_q, conf_prev_q;
  logic   confirm_rise;

  logic       dec_sreg, dec_smem, dec_sdisplay, dec_smemtoreg, dec_smux5, dec_smux32;
  logic [1:0] dec_smux16;
  logic [2:0] dec_smux_pc;
  logic [3:0] dec_salu;
  logic       dec_legal, dec_in, dec_hlt, dec_ovf;
  logic       ovf_trap;

  // The zero flag steers the PC mux in the datapath; control never needs it.
  logic unused_flags;
  assign unused_flags = zero_i ^ of_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StDecode;
      conf_meta_q <= 1'b0;
      conf_sync_q <= 1'b0;
      conf_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      conf_meta_q <= confirm_i;
      conf_sync_q <= conf_meta_q;
      conf_prev_q <= conf_sync_q;
    end
  end

  assign confirm_rise = conf_sync_q & ~conf_prev_q;

  always_comb begin
    dec_sreg      = 1'b0;
    dec_smem      = 1'b0;
    dec_sdisplay  = 1'b0;
    dec_smemtoreg = 1'b0;
    dec_smux5     = 1'b0;
    dec_smux32    = 1'b0;
    dec_smux16    = 2'b00;
    dec_smux_pc   = PcNext;
    dec_salu      = AluAdd;
    dec_legal     = 1'b1;
    dec_in        = 1'b0;
    dec_hlt       = 1'b0;
    dec_ovf       = 1'b0;
    case (opcode_i)
      OpRType: begin
        dec_sreg = 1'b1;
        case (funct_i)
          FnAdd: dec_ovf = 1'b1;
          FnSub: begin
            dec_salu = AluSub;
            dec_ovf  = 1'b1;
          end
          FnAnd: dec_salu = AluAnd;
          FnOr:  dec_salu = AluOr;
          FnSlt: dec_salu = AluSlt;
          FnSll: dec_salu = AluSll;
          FnSrl: dec_salu = AluSrl;
          FnJr: begin
            dec_sreg    = 1'b0;
            dec_smux_pc = PcJumpReg;
          end
          default: begin
            dec_sreg  = 1'b0;
            dec_legal = 1'b0;
          end
        endcase
      end
      OpAddi: begin
        dec_sreg   = 1'b1;
        dec_smux5  = 1'b1;
        dec_smux32 = 1'b1;
        dec_ovf    = 1'b1;
      end
      OpLw: begin
        dec_sreg      = 1'b1;
        dec_smux5     = 1'b1;
        dec_smux32    = 1'b1;
        dec_smemtoreg = 1'b1;
      end
      OpSw: begin
        dec_smem   = 1'b1;
        dec_smux32 = 1'b1;
      end
      OpBeq: begin
        dec_salu    = AluSub;
        dec_smux_pc = PcBeq;
      end
      OpBne: begin
        dec_salu    = AluSub;
        dec_smux_pc = PcBne;
      end
      OpJ:  dec_smux_pc = PcJump;
      OpIn: begin
        // Writes switches + $0 into rt, so the ALU adds the 01 operand to rs.
        dec_sreg   = 1'b1;
        dec_smux5  = 1'b1;
        dec_smux32 = 1'b1;
        dec_smux16 = 2'b01;
        dec_in     = 1'b1;
      end
      OpOut: dec_sdisplay = 1'b1;
      OpHlt: dec_hlt = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    ovf_trap = 1'b0;
`ifdef OVF_TRAP_EN
    ovf_trap = of_i & dec_ovf;
`endif
  end

  always_comb begin
    state_d     = state_q;
    halt_o      = 1'b1;
    sreg_o      = 1'b0;
    smem_o      = 1'b0;
    sdisplay_o  = 1'b0;
    smemtoreg_o = 1'b0;
    smux5_o     = 1'b0;
    smux32_o    = 1'b0;
    smux16_o    = 2'b00;
    smux_pc_o   = PcNext;
    salu_o      = AluAdd;
    illegal_o   = 1'b0;

    if (state_q != StHalted) begin
      smemtoreg_o = dec_smemtoreg;
      smux5_o     = dec_smux5;
      smux32_o    = dec_smux32;
      smux16_o    = dec_smux16;
      smux_pc_o   = dec_smux_pc;
      salu_o      = dec_salu;
    end

    unique case (state_q)
      StDecode: begin
        illegal_o = ~dec_legal;
        if (dec_in) begin
          state_d = StWaitIn;
        end else if (dec_hlt) begin
          state_d = StHalted;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        halt_o     = 1'b0;
        sreg_o     = dec_sreg;
        smem_o     = dec_smem;
        sdisplay_o = dec_sdisplay;
        state_d    = StDecode;
        if (ovf_trap) begin
          halt_o  = 1'b1;
          sreg_o  = 1'b0;
          state_d = StHalted;
        end
      end
      StWaitIn: begin
        if (confirm_rise) begin
          state_d = StExec;
        end
      end
      StHalted: state_d = StHalted;
    endcase

    if (reset_i) begin
      halt_o      = 1'b1;
      sreg_o      = 1'b0;
      smem_o      = 1'b0;
      sdisplay_o  = 1'b0;
      smemtoreg_o = 1'b0;
      smux5_o     = 1'b0;
      smux32_o    = 1'b0;
      smux16_o    = 2'b00;
      smux_pc_o   = PcNext;
      salu_o      = AluAdd;
      illegal_o   = 1'b0;
    end
  end

  assign state_out_o = state_q;

endmodule
